// File: rtl/hs_arb_pkg.sv
// Shared types and constants for the handshake round-robin arbiter.
// Holds the FSM state encoding, the synchronizer depth and the default ack timeout.
package hs_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } arb_state_t;

  localparam int SYNC_DEPTH = 2;
  localparam int TO_CYC_DEF = 255;

endpackage

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Round-robin pick, combinational: the first valid requester after last_grant, wrapping modulo N_REQ.
// Zero latency; any is high when at least one valid bit is set.
module rr_pick #(
  parameter int N_REQ = 4,
  parameter int GW    = 2
) (
  input  logic [N_REQ-1:0] valid,
  input  logic [GW-1:0]    last_grant,
  output logic [GW-1:0]    grant,
  output logic             any
);

  int   idx;
  logic found;

  always_comb begin
    grant = '0;
    idx   = 0;
    found = 1'b0;
    any   = |valid;
    // last_grant itself is checked last, so a lone requester is still re-granted.
    for (int i = 1; i <= N_REQ; i++) begin
      idx = (int'(last_grant) + i) % N_REQ;
      if (!found && valid[idx]) begin
        grant = idx[GW-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Arbitrates N_REQ valid/ready requesters onto one 4-phase bundled-data channel; ready pulses one cycle
// after grant, the next grant waits for the full req/ack cycle. Define ARB_TIMEOUT_EN to add timeout_err.
module hs_rr_arbiter
  import hs_arb_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int DW     = 3,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         valid,
  input  logic [N_REQ*DW-1:0]      data,
  output logic [N_REQ-1:0]         ready,
  output logic                     req_out,
  input  logic                     ack_in,
  output logic [DW-1:0]            data_out,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic                     timeout_err
`endif
);

  localparam int GW = $clog2(N_REQ);
  localparam logic [GW-1:0] LAST_INIT = GW'(N_REQ - 1);

  if (N_REQ < 2 || N_REQ > 8 || TO_CYC < 1 || TO_CYC > 255) begin : g_bad_cfg
    $error("hs_rr_arbiter: N_REQ must be 2..8 and TO_CYC 1..255");
  end

  arb_state_t            state;
  logic [GW-1:0]         last_grant;
  logic [GW-1:0]         grant;
  logic                  any;
  logic [DW-1:0]         data_sel;
  logic [SYNC_DEPTH-1:0] ack_sync;
  logic                  ack_s;

  rr_pick #(
    .N_REQ (N_REQ),
    .GW    (GW)
  ) u_pick (
    .valid      (valid),
    .last_grant (last_grant),
    .grant      (grant),
    .any        (any)
  );

  assign data_sel = data[grant*DW +: DW];
  assign ack_s    = ack_sync[SYNC_DEPTH-1];
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_sync <= '0;
    else        ack_sync <= {ack_sync[SYNC_DEPTH-2:0], ack_in};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_out    <= 1'b0;
      ready      <= '0;
      data_out   <= '0;
      grant_id   <= '0;
      last_grant <= LAST_INIT;
    end else begin
      ready <= '0;
      case (state)
        // A stale ack from the stage blocks arbitration until it returns low.
        IDLE: begin
          if (any && !ack_s) begin
            data_out     <= data_sel;
            grant_id     <= grant;
            ready[grant] <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP: begin
          if (!ack_s) begin
            req_out <= 1'b1;
            state   <= REQ_HI;
          end
        end
        REQ_HI: begin
          if (ack_s) begin
            req_out <= 1'b0;
            state   <= REQ_LO;
          end
        end
        REQ_LO: begin
          if (!ack_s) begin
            last_grant <= grant_id;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TO_CYC - 1);

  logic [7:0] to_cnt;
  logic       waiting;
  logic       leaving;

  assign waiting = (state == REQ_HI) || (state == REQ_LO);
  assign leaving = ((state == REQ_HI) && ack_s) || ((state == REQ_LO) && !ack_s);

  // Counts cycles spent in one handshake phase; the error is only reported, the FSM keeps waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (!waiting || leaving) begin
      to_cnt <= '0;
    end else begin
      if (to_cnt != 8'hff) to_cnt <= to_cnt + 8'd1;
      if (to_cnt == TO_LIM) timeout_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_hs_rr_arbiter.sv
// Directed bench for hs_rr_arbiter with a 3-cycle-delay 4-phase ack model.
// Build with ARB_TIMEOUT_EN defined to also exercise the timeout flag.
module tb_hs_rr_arbiter;

  localparam int N  = 4;
  localparam int DW = 3;
  localparam int TO = 10;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    valid = '0;
  logic [N*DW-1:0] data = '0;
  logic [N-1:0]    ready;
  logic            req_out;
  logic            ack_in;
  logic [DW-1:0]   data_out;
  logic [1:0]      grant_id;
  logic            busy;
`ifdef ARB_TIMEOUT_EN
  logic            timeout_err;
`endif

  int checks = 0;
  int errors = 0;

  logic       ack_auto = 1'b1;
  logic       ack_force = 1'b0;
  logic [2:0] ack_pipe;

  hs_rr_arbiter #(
    .N_REQ  (N),
    .DW     (DW),
    .TO_CYC (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .data        (data),
    .ready       (ready),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .data_out    (data_out),
    .grant_id    (grant_id),
    .busy        (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  always #5 clk = ~clk;

  // Downstream stage: ack follows req_out three clocks later, reset with the arbiter.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_pipe <= '0;
    else        ack_pipe <= {ack_pipe[1:0], req_out};
  end
  assign ack_in = ack_auto ? ack_pipe[2] : ack_force;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input logic v, input int maxc, output int n);
    n = 0;
    while (req_out !== v && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic wait_idle(input int maxc, output int n);
    n = 0;
    while (busy !== 1'b0 && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic wait_ready(input int maxc, output int n);
    n = 0;
    while (ready === '0 && n < maxc) begin
      step();
      n++;
    end
  endtask

  task automatic set_slice(input int i, input logic [DW-1:0] v);
    data[i*DW +: DW] = v;
  endtask

  initial begin
    int n;
    int bad;
    logic [DW-1:0] exp_dat [N];
    exp_dat = '{3'd1, 3'd2, 3'd3, 3'd6};

    // Reset state
    step();
    step();
    chk("rst_req_out", req_out, 0);
    chk("rst_ready", ready, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_busy", busy, 0);
`ifdef ARB_TIMEOUT_EN
    chk("rst_timeout", timeout_err, 0);
`endif

    // Single requester, full 4-phase cycle
    rst_n = 1'b1;
    valid = 4'b0001;
    set_slice(0, 3'b101);
    step();
    chk("t1_ready", ready, 4'b0001);
    chk("t1_data_setup", data_out, 5);
    chk("t1_req_setup", req_out, 0);
    chk("t1_busy", busy, 1);
    valid = 4'b0000;
    step();
    chk("t1_req_hi", req_out, 1);
    chk("t1_ready_pulse", ready, 0);
    wait_req(1'b0, 40, n);
    chk("t1_req_hi_cycles", n, 6);
    chk("t1_data_hold", data_out, 5);
    wait_idle(40, n);
    chk("t1_req_lo_cycles", n, 6);
    chk("t1_busy_fall", busy, 0);

    // All requesters held: round-robin from last_grant=3
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    data  = {3'd6, 3'd3, 3'd2, 3'd1};
    valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready(40, n);
      chk("t2_ready_onehot", ready, 4'b0001 << (k % N));
      chk("t2_grant_id", grant_id, k % N);
      chk("t2_data_out", data_out, exp_dat[k % N]);
      step();
      chk("t2_ready_clear", ready, 0);
    end
    valid = '0;
    wait_idle(40, n);
    chk("t2_idle", busy, 0);

    // A late valid waits for the next arbitration
    data  = '0;
    set_slice(0, 3'd4);
    set_slice(2, 3'd7);
    valid = 4'b0001;
    wait_ready(10, n);
    chk("t3_grant0", grant_id, 0);
    valid = 4'b0000;
    wait_req(1'b1, 10, n);
    chk("t3_req_hi", req_out, 1);
    valid = 4'b0100;
    bad = 0;
    n = 0;
    while (busy !== 1'b0 && n < 40) begin
      if (ready !== '0 || data_out !== 3'd4) bad++;
      step();
      n++;
    end
    chk("t3_no_early_grant", bad, 0);
    chk("t3_idle_reached", busy, 0);
    wait_ready(10, n);
    chk("t3_ready2", ready, 4'b0100);
    chk("t3_grant2", grant_id, 2);
    chk("t3_data2", data_out, 7);
    valid = '0;
    wait_idle(40, n);

    // Reset in REQ_HI
    set_slice(0, 3'd3);
    set_slice(1, 3'd5);
    valid = 4'b0001;
    wait_req(1'b1, 10, n);
    chk("t4_in_req_hi", req_out, 1);
    rst_n = 1'b0;
    #1;
    chk("t4_req_drop", req_out, 0);
    chk("t4_data_clr", data_out, 0);
    chk("t4_busy_clr", busy, 0);
    step();
    step();
    rst_n = 1'b1;
    valid = 4'b0010;
    step();
    chk("t4_ready1", ready, 4'b0010);
    chk("t4_grant1", grant_id, 1);
    chk("t4_data1", data_out, 5);
    valid = '0;
    wait_idle(40, n);
    chk("t4_idle", busy, 0);

    // Stale ack high at IDLE blocks the request
    ack_auto  = 1'b0;
    ack_force = 1'b1;
    step();
    step();
    step();
    valid = 4'b0001;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step();
      if (req_out !== 1'b0 || busy !== 1'b0 || ready !== '0) bad++;
    end
    chk("t5_blocked", bad, 0);
    ack_force = 1'b0;
    ack_auto  = 1'b1;
    wait_ready(10, n);
    chk("t5_grant_delay", n, 3);
    chk("t5_grant0", grant_id, 0);
    valid = '0;
    wait_req(1'b1, 10, n);
    chk("t5_req_rise", req_out, 1);
    wait_idle(40, n);
    chk("t5_done", busy, 0);

`ifdef ARB_TIMEOUT_EN
    // Ack never arrives: sticky timeout after TO cycles in REQ_HI
    ack_auto  = 1'b0;
    ack_force = 1'b0;
    valid = 4'b0001;
    wait_ready(10, n);
    valid = '0;
    wait_req(1'b1, 10, n);
    for (int k = 0; k < TO - 1; k++) step();
    chk("t6_before_to", timeout_err, 0);
    step();
    chk("t6_at_to", timeout_err, 1);
    chk("t6_still_waiting", req_out, 1);
    ack_auto = 1'b1;
    wait_idle(60, n);
    chk("t6_done", busy, 0);
    chk("t6_sticky", timeout_err, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_rr_arbiter.md
HS_RR_ARBITER -- requirements
Module: hs_rr_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of synchronous requesters (2..8).
REQ-002 Parameter DW, default 3, data width of the bundled-data channel.
REQ-003 Parameter TO_CYC, default 255, ack timeout in clk cycles (used only under REQ-029).
REQ-004 clk  input  1  system clock, rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 valid  input  N_REQ  per-requester request, level, held until the matching ready.
REQ-007 data  input  N_REQ*DW  per-requester payload; slice i is data[i*DW +: DW].
REQ-008 ready  output  N_REQ  one-cycle pulse: payload captured, requester may drop valid or change data.
REQ-009 req_out  output  1  4-phase request to the downstream async pipeline stage.
REQ-010 ack_in  input  1  4-phase acknowledge from the stage, asynchronous to clk.
REQ-011 data_out  output  DW  bundled data to the stage.
REQ-012 grant_id  output  clog2(N_REQ)  index of the requester owning the current transfer.
REQ-013 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 ack_in SHALL pass through a 2-flop synchronizer; ack_s denotes the output, latency 2 cycles.
REQ-015 FSM states SHALL be IDLE, SETUP, REQ_HI, REQ_LO.
REQ-016 IDLE: if any valid bit is high, SHALL pick grant g by round-robin starting at last_grant+1 modulo N_REQ, register data_out=data[g] and grant_id=g, pulse ready[g], and move to SETUP.
REQ-017 SETUP: one cycle with data_out stable and req_out low (bundled-data setup); SHALL then move to REQ_HI.
REQ-018 REQ_HI: req_out SHALL be 1; when ack_s==1, SHALL drop req_out on the next edge and move to REQ_LO.
REQ-019 REQ_LO: req_out SHALL be 0; when ack_s==0, SHALL set last_grant=grant_id and move to IDLE.
REQ-020 data_out SHALL not change from SETUP entry until REQ_LO exit.
REQ-021 A single valid requester SHALL be granted repeatedly, with no forced idle beyond the protocol itself.
REQ-022 A valid bit that rises while busy SHALL be ignored until the next IDLE arbitration; it is not lost, because valid is held.
REQ-023 If ack_s==1 in IDLE or SETUP (protocol violation), the FSM SHALL stay in IDLE or hold in SETUP until ack_s==0 before raising req_out.
REQ-024 At most one ready bit SHALL be high in any cycle.

Reset
REQ-025 On assertion of rst_n, SHALL asynchronously set state=IDLE, req_out=0, ready=0, data_out=0, grant_id=0, last_grant=N_REQ-1, and clear the synchronizer flops.
REQ-026 Reset asserted mid-transfer SHALL drop req_out immediately; the downstream stage is reset by the same rst_n.
REQ-027 Deassertion of rst_n SHALL be synchronized externally; the first arbitration occurs on the first clk edge after release.

Configuration
REQ-028 Macro ARB_TIMEOUT_EN.
REQ-029 Defined: an 8-bit counter runs in REQ_HI and REQ_LO and is cleared on each state change; reaching TO_CYC SHALL set a sticky output timeout_err (1 bit), cleared only by reset; the FSM keeps waiting, with no abort.
REQ-030 Not defined: the timeout_err port and counter are absent; behaviour is otherwise identical.

Structure
REQ-031 The state enum, the 2-flop synchronizer depth constant and the TO_CYC default SHALL live in package hs_arb_pkg.
REQ-032 The round-robin next-grant logic SHALL be sub-module rr_pick (inputs valid and last_grant; outputs grant and any).

Verification
REQ-033 Single requester: valid=4'b0001, data[0]=3'b101, ack model 3-cycle delay -> ready[0] one cycle, data_out=5 before req_out rises, full 4-phase completes, busy falls.
REQ-034 All valid=4'b1111 held, last_grant=3 after reset -> grant order 0,1,2,3,0 with exactly one ready per transfer.
REQ-035 valid[2] raised during REQ_HI of requester 0 -> granted at the next IDLE, not earlier; data_out unchanged during transfer 0.
REQ-036 rst_n pulsed low during REQ_HI -> req_out=0 and data_out=0 immediately; after release and valid=4'b0010, grant_id=1.
REQ-037 ack_in held high at IDLE with valid=4'b0001 -> req_out stays 0 until ack_in falls, then the normal transfer proceeds.
REQ-038 ARB_TIMEOUT_EN defined, TO_CYC=10, ack never rises -> timeout_err=1 after 10 cycles in REQ_HI; it stays 1 after ack later completes the transfer.
